// File: rtl/ram_bank.sv
// ram_bank: single-port synchronous RAM with byte enables, 1/2-cycle read latency,
// selectable read-during-write return and a sweep engine that fills the array with INIT_VALUE.
module ram_bank #(
    parameter int              DATA_W       = 32,
    parameter int              ADDR_W       = 5,
    parameter int              DEPTH        = 32,
    parameter int              READ_LATENCY = 1,
    parameter int              RDW_MODE     = 0,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                wena,
    input  logic [DATA_W/8-1:0] be,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   data_in,
    output logic [DATA_W-1:0]   data_out,
    output logic                rvalid,
    input  logic                clr,
    output logic                busy
);
    localparam int NB = DATA_W / 8;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                acc, in_rng, out_v;
    logic [DATA_W-1:0]   old_w, new_w, ret_w, out_w;
    logic [DATA_W-1:0]   s1_q, dout_q;
    logic                s1v_q, rv_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == CLEAR) begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        end else if (clr) begin
            state_d = CLEAR;
            ptr_d   = '0;
        end
    end

    // An access coinciding with an accepted clear is dropped.
    assign acc    = (state_q == IDLE) && ena && !clr;
    assign in_rng = 32'(addr) < DEPTH;
    assign old_w  = in_rng ? mem[addr] : '0;

    always_comb begin
        new_w = old_w;
        for (int i = 0; i < NB; i++)
            if (be[i]) new_w[8*i +: 8] = data_in[8*i +: 8];
    end

    assign ret_w = !in_rng ? '0 : (wena && RDW_MODE == 1) ? new_w : old_w;
    assign out_v = (READ_LATENCY == 2) ? s1v_q : acc;
    assign out_w = (READ_LATENCY == 2) ? s1_q : ret_w;

    always_ff @(posedge clk) begin
        if (state_q == CLEAR)
            mem[ptr_q] <= INIT_VALUE;
        else if (acc && wena && in_rng)
            mem[addr] <= new_w;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            s1_q    <= '0;
            s1v_q   <= 1'b0;
            dout_q  <= '0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            s1_q    <= ret_w;
            s1v_q   <= acc;
            rv_q    <= out_v;
            if (out_v) dout_q <= out_w;
        end
    end

    assign data_out = dout_q;
    assign rvalid   = rv_q;
    assign busy     = (state_q == CLEAR);
endmodule

// File: tb/tb_ram_bank.sv
// tb_ram_bank: drives two ram_bank configurations with shared stimulus and checks them
// against a word-array reference model, a directed vector table and reset/clear sequences.
module tb_ram_bank;
    localparam logic [31:0] INIT1 = 32'hA5C3_0F00;

    logic        clk, rst_n, ena, wena, clr;
    logic [3:0]  be;
    logic [4:0]  addr;
    logic [31:0] data_in;
    logic [31:0] do0, do1;
    logic        rv0, rv1, busy0, busy1;

    int checks = 0;
    int errors = 0;

    ram_bank u0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .wena(wena), .be(be), .addr(addr),
        .data_in(data_in), .data_out(do0), .rvalid(rv0), .clr(clr), .busy(busy0)
    );

    ram_bank #(.DEPTH(20), .READ_LATENCY(2), .RDW_MODE(1), .INIT_VALUE(INIT1)) u1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .wena(wena), .be(be), .addr(addr),
        .data_in(data_in), .data_out(do1), .rvalid(rv1), .clr(clr), .busy(busy1)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // reference model: per-configuration word array, sweep countdown and result delay line
    int          dep [2] = '{32, 20};
    int          lat [2] = '{1, 2};
    bit          rdw [2] = '{0, 1};
    logic [31:0] ini [2] = '{32'h0, INIT1};
    logic [31:0] mm  [2][32];
    int          cl  [2];
    logic        pv  [2], erv [2];
    logic [31:0] pd  [2], edo [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            cl[k] = dep[k]; pv[k] = 0; pd[k] = 0; erv[k] = 0; edo[k] = 0;
        end
    endtask

    task automatic model_edge();
        logic [31:0] mask, old, mrg, w;
        logic acc;
        if (!rst_n) return;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        for (int k = 0; k < 2; k++) begin
            acc = 0;
            w   = 0;
            if (cl[k] > 0) begin
                mm[k][dep[k] - cl[k]] = ini[k];
                cl[k]--;
            end else if (clr) cl[k] = dep[k];
            else acc = ena;
            if (acc && int'(addr) < dep[k]) begin
                old = mm[k][addr];
                mrg = (old & ~mask) | (data_in & mask);
                if (wena) mm[k][addr] = mrg;
                w = (wena && rdw[k]) ? mrg : old;
            end
            if (lat[k] == 1) begin
                erv[k] = acc;
                if (acc) edo[k] = w;
            end else begin
                erv[k] = pv[k];
                if (pv[k]) edo[k] = pd[k];
                pv[k] = acc;
                pd[k] = w;
            end
        end
    endtask

    task automatic cmp_all();
        chk("m_rvalid0", rv0, erv[0]);
        chk("m_dout0", do0, edo[0]);
        chk("m_busy0", busy0, cl[0] > 0);
        chk("m_rvalid1", rv1, erv[1]);
        chk("m_dout1", do1, edo[1]);
        chk("m_busy1", busy1, cl[1] > 0);
    endtask

    task automatic step(input logic e, input logic w, input logic [3:0] b, input logic [4:0] a,
                        input logic [31:0] d, input logic c);
        ena = e; wena = w; be = b; addr = a; data_in = d; clr = c;
        @(posedge clk);
        model_edge();
        #1;
        cmp_all();
    endtask

    // Count edges until each bank drops busy; optionally attempt writes to addr 5 early on.
    task automatic wait_sweep(input int wr_attempts);
        int n0 = 0, n1 = 0;
        for (int i = 1; i <= 100; i++) begin
            if (i <= wr_attempts) step(1, 1, 4'hF, 5'd5, 32'h0BAD_F00D, 0);
            else step(0, 0, 4'h0, 5'd0, 32'h0, 0);
            if (n0 == 0 && !busy0) n0 = i;
            if (n1 == 0 && !busy1) n1 = i;
            if (n0 != 0 && n1 != 0) break;
        end
        chk("sweep_len0", n0, 32);
        chk("sweep_len1", n1, 20);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_busy0"}, busy0, 1);
        chk({nm, "_rv0"}, rv0, 0);
        chk({nm, "_do0"}, do0, 0);
        chk({nm, "_busy1"}, busy1, 1);
        chk({nm, "_rv1"}, rv1, 0);
        chk({nm, "_do1"}, do1, 0);
    endtask

    typedef struct {
        logic        ena, wena;
        logic [3:0]  be;
        logic [4:0]  addr;
        logic [31:0] din;
        logic        rv0;
        logic [31:0] do0;
        logic        rv1;
        logic [31:0] do1;
    } vec_t;

    vec_t tv [19];

    initial begin
        tv[0]  = '{1, 1, 4'hF, 5'd0,  32'h1234_5678, 1, 32'h0,         0, 32'h0};
        tv[1]  = '{1, 1, 4'h3, 5'd0,  32'h8765_4321, 1, 32'h1234_5678, 1, 32'h1234_5678};
        tv[2]  = '{1, 0, 4'h0, 5'd0,  32'h0,         1, 32'h1234_4321, 1, 32'h1234_4321};
        tv[3]  = '{0, 0, 4'h0, 5'd0,  32'h0,         0, 32'h1234_4321, 1, 32'h1234_4321};
        tv[4]  = '{1, 1, 4'hF, 5'd3,  32'hAAAA_AAAA, 1, 32'h0,         0, 32'h1234_4321};
        tv[5]  = '{1, 1, 4'hF, 5'd3,  32'h5555_5555, 1, 32'hAAAA_AAAA, 1, 32'hAAAA_AAAA};
        tv[6]  = '{1, 0, 4'h0, 5'd3,  32'h0,         1, 32'h5555_5555, 1, 32'h5555_5555};
        tv[7]  = '{1, 1, 4'hF, 5'd1,  32'h11,        1, 32'h0,         1, 32'h5555_5555};
        tv[8]  = '{1, 1, 4'hF, 5'd2,  32'h22,        1, 32'h0,         1, 32'h11};
        tv[9]  = '{1, 1, 4'hF, 5'd3,  32'h33,        1, 32'h5555_5555, 1, 32'h22};
        tv[10] = '{1, 0, 4'h0, 5'd1,  32'h0,         1, 32'h11,        1, 32'h33};
        tv[11] = '{1, 0, 4'h0, 5'd2,  32'h0,         1, 32'h22,        1, 32'h11};
        tv[12] = '{1, 0, 4'h0, 5'd3,  32'h0,         1, 32'h33,        1, 32'h22};
        tv[13] = '{1, 1, 4'hF, 5'd5,  32'hDEAD_BEEF, 1, 32'h0,         1, 32'h33};
        tv[14] = '{1, 1, 4'h0, 5'd5,  32'hFFFF_FFFF, 1, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF};
        tv[15] = '{1, 0, 4'h0, 5'd5,  32'h0,         1, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF};
        tv[16] = '{1, 1, 4'hF, 5'd25, 32'hCAFE_F00D, 1, 32'h0,         1, 32'hDEAD_BEEF};
        tv[17] = '{1, 0, 4'h0, 5'd25, 32'h0,         1, 32'hCAFE_F00D, 1, 32'h0};
        tv[18] = '{0, 0, 4'h0, 5'd0,  32'h0,         0, 32'hCAFE_F00D, 1, 32'h0};

        rst_n = 1; ena = 0; wena = 0; be = 0; addr = 0; data_in = 0; clr = 0;
        model_reset();
        #2 rst_n = 0;
        #8 chk_reset_outputs("por");
        #2 rst_n = 1;
        wait_sweep(0);

        for (int i = 0; i < 19; i++) begin
            step(tv[i].ena, tv[i].wena, tv[i].be, tv[i].addr, tv[i].din, 0);
            chk($sformatf("tv%0d_rv0", i), rv0, tv[i].rv0);
            chk($sformatf("tv%0d_do0", i), do0, tv[i].do0);
            chk($sformatf("tv%0d_rv1", i), rv1, tv[i].rv1);
            chk($sformatf("tv%0d_do1", i), do1, tv[i].do1);
        end

        // clear request with a simultaneous write that must be dropped
        step(1, 1, 4'hF, 5'd5, 32'h0BAD_F00D, 1);
        chk("clr_busy0", busy0, 1);
        chk("clr_busy1", busy1, 1);
        wait_sweep(5);
        step(1, 0, 4'h0, 5'd5, 32'h0, 0);
        chk("clr_rd0", do0, 32'h0);
        chk("clr_rv0", rv0, 1);
        step(0, 0, 4'h0, 5'd0, 32'h0, 0);
        chk("clr_rd1", do1, INIT1);
        chk("clr_rv1", rv1, 1);

        // reset while a read result is on the output / in flight
        step(1, 1, 4'hF, 5'd1, 32'h7777_0001, 0);
        step(1, 0, 4'h0, 5'd1, 32'h0, 0);
        #2 rst_n = 0;
        model_reset();
        #1 chk_reset_outputs("rd_rst");
        step(1, 0, 4'h0, 5'd1, 32'h0, 0);
        #3 rst_n = 1;
        wait_sweep(0);

        // reset mid-sweep at pointer 10
        step(0, 0, 4'h0, 5'd0, 32'h0, 1);
        for (int i = 0; i < 10; i++) step(1, 0, 4'h0, 5'd2, 32'h0, 0);
        #2 rst_n = 0;
        model_reset();
        #1 chk_reset_outputs("sw_rst");
        #3 rst_n = 1;
        wait_sweep(0);

        for (int i = 0; i < 400; i++) begin
            logic        e, w, c;
            logic [3:0]  b;
            logic [4:0]  a;
            logic [31:0] d;
            c = ($urandom_range(0, 99) < 2);
            e = ($urandom_range(0, 9) < 8);
            w = $urandom_range(0, 1);
            b = 4'($urandom);
            a = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            d = $urandom;
            step(e, w, b, a, d, c);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
